wb_select_stage: RTL and testbench

Registered write-back stage that replaces the single-cycle write-back mux. It sits between the data-memory stage and the register file. It captures the MEM-stage result bundle into a MEM/WB pipeline register, with stall and flush control. It selects among ALU result, aligned load data, link address (PC+4) and immediate, and drives the register-file write port.

---
 rtl/wb_select_stage_pkg.sv | 24 ++
 rtl/wb_select_stage_if.sv | 51 +++++
 rtl/wb_select_stage_load_align.sv | 54 +++++
 rtl/wb_select_stage.sv | 80 ++++++++
 tb/tb_wb_select_stage.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_select_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared encodings and constants for the write-back select stage.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Write-back source select encodings
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;
    localparam logic [1:0] WB_SEL_IMM  = 2'd3;

    // Load size encodings (3 is reserved and treated as a word)
    localparam logic [1:0] LOAD_BYTE = 2'd0;
    localparam logic [1:0] LOAD_HALF = 2'd1;
    localparam logic [1:0] LOAD_WORD = 2'd2;

    // Increment applied to the PC for link writes
    localparam int unsigned LINK_INC = 4;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_select_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_select_stage_if
// Description : MEM-stage bundle, pipeline control and register-file write
//               port of the write-back select stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_select_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    // MEM-stage bundle
    logic                  mem_valid;
    logic [XLEN-1:0]       mem_alu_result;
    logic [XLEN-1:0]       mem_dmem_read_data;
    logic [XLEN-1:0]       mem_pc;
    logic [XLEN-1:0]       mem_imm;
    logic [1:0]            mem_wb_sel;
    logic [1:0]            mem_load_size;
    logic                  mem_load_unsigned;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;

    // Pipeline control
    logic                  stall;
    logic                  flush;

    // Register-file write port
    logic                  wb_valid;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;

    // Upstream pipeline / environment side
    modport master (
        output mem_valid, mem_alu_result, mem_dmem_read_data, mem_pc, mem_imm,
               mem_wb_sel, mem_load_size, mem_load_unsigned, mem_rd, mem_reg_write,
               stall, flush,
        input  wb_valid, wb_reg_write, wb_rd, wb_data
    );

    // Write-back stage side
    modport slave (
        input  mem_valid, mem_alu_result, mem_dmem_read_data, mem_pc, mem_imm,
               mem_wb_sel, mem_load_size, mem_load_unsigned, mem_rd, mem_reg_write,
               stall, flush,
        output wb_valid, wb_reg_write, wb_rd, wb_data
    );

endinterface : wb_select_stage_if
`default_nettype wire

// File: rtl/wb_select_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half/word lane of a data-memory
//               read and zero- or sign-extends it to XLEN. Combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] i_rdata,
    input  wire logic [1:0]      i_offset,
    input  wire logic [1:0]      i_size,
    input  wire logic            i_unsigned,
    output logic      [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_word;
    logic        w_fill;

    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];
    assign w_word = i_rdata[31:0];

    // Fill the whole word with the extension bit, then overlay the lane
    always_comb begin
        w_fill = 1'b0;
        o_data = '0;
        case (i_size)
            LOAD_BYTE: begin
                w_fill      = ~i_unsigned & w_byte[7];
                o_data      = {XLEN{w_fill}};
                o_data[7:0] = w_byte;
            end
            LOAD_HALF: begin
                w_fill       = ~i_unsigned & w_half[15];
                o_data       = {XLEN{w_fill}};
                o_data[15:0] = w_half;
            end
            default: begin
                // Word and the reserved size both use the low 32 bits
                w_fill       = ~i_unsigned & w_word[31];
                o_data       = {XLEN{w_fill}};
                o_data[31:0] = w_word;
            end
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_select_stage
// Description : Registered write-back stage. Selects ALU / aligned load /
//               link / immediate data from the MEM bundle and captures it in
//               the MEM/WB register with stall and flush control.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    wb_select_stage_if.slave  bus
);

    logic [XLEN-1:0]       w_load_data;
    logic [XLEN-1:0]       w_link_data;
    logic [XLEN-1:0]       w_sel_data;

    logic                  r_valid;
    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_data;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_rdata    (bus.mem_dmem_read_data),
        .i_offset   (bus.mem_alu_result[1:0]),
        .i_size     (bus.mem_load_size),
        .i_unsigned (bus.mem_load_unsigned),
        .o_data     (w_load_data)
    );

    // Link address wraps modulo 2^XLEN
    assign w_link_data = bus.mem_pc + XLEN'(LINK_INC);

    // Write-back source mux on the MEM-stage bundle
    always_comb begin
        w_sel_data = bus.mem_alu_result;
        case (bus.mem_wb_sel)
            WB_SEL_ALU:  w_sel_data = bus.mem_alu_result;
            WB_SEL_LOAD: w_sel_data = w_load_data;
            WB_SEL_LINK: w_sel_data = w_link_data;
            WB_SEL_IMM:  w_sel_data = bus.mem_imm;
            default:     w_sel_data = bus.mem_alu_result;
        endcase
    end

    // MEM/WB register: reset > flush > stall > capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_data      <= '0;
        end else if (bus.flush) begin
            // Only the qualifiers are dropped; rd/data are don't-care afterwards
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (!bus.stall) begin
            r_valid     <= bus.mem_valid;
            r_reg_write <= bus.mem_reg_write;
            r_rd        <= bus.mem_rd;
            r_data      <= w_sel_data;
        end
    end

    // Outputs depend only on the register; writes to x0 never reach the file
    assign bus.wb_valid     = r_valid;
    assign bus.wb_reg_write = r_valid & r_reg_write & (r_rd != '0);
    assign bus.wb_rd        = r_rd;
    assign bus.wb_data      = r_data;

endmodule : wb_select_stage
`default_nettype wire

// File: tb/tb_wb_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_select_stage
// Description : Directed self-checking bench for wb_select_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_select_stage;
    import wb_pkg::*;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    wb_select_stage_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) bus ();

    wb_select_stage #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one MEM bundle at the falling edge
    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [1:0] size, input logic uns, input logic [4:0] rd,
                         input logic rw);
        @(negedge clk);
        bus.mem_valid          = v;
        bus.mem_wb_sel         = sel;
        bus.mem_alu_result     = alu;
        bus.mem_dmem_read_data = rdata;
        bus.mem_pc             = pc;
        bus.mem_imm            = imm;
        bus.mem_load_size      = size;
        bus.mem_load_unsigned  = uns;
        bus.mem_rd             = rd;
        bus.mem_reg_write      = rw;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, WB_SEL_ALU, 32'hDEAD_BEEF, '0, '0, '0, LOAD_WORD, 1'b0, 5'd7, 1'b1);
        sample();
        sample();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.wb_valid); end
        checks++; if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.wb_reg_write); end
        checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", bus.wb_rd); end
        checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=00000000", bus.wb_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        drive(1'b1, WB_SEL_ALU, 32'h0000_1234, 32'h5555_5555, 32'h100, 32'h200, LOAD_WORD, 1'b0, 5'd5, 1'b1);
        sample();
        checks++; if (bus.wb_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_data got=%h exp=00001234", bus.wb_data); end
        checks++; if (bus.wb_rd !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0d exp=5", bus.wb_rd); end
        checks++; if (bus.wb_reg_write !== 1'b1) begin errors++; $display("FAIL alu_we got=%b exp=1", bus.wb_reg_write); end
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got=%b exp=1", bus.wb_valid); end
    endtask

    task automatic test_load();
        // Read word bytes, LSB first: 01, 7F, FF, 80
        logic [31:0] rd_word;
        logic [31:0] addr [8];
        logic [1:0]  size [8];
        logic        uns  [8];
        logic [31:0] exp  [8];
        rd_word = 32'h80FF_7F01;
        addr[0] = 32'h1003; size[0] = LOAD_BYTE; uns[0] = 1'b0; exp[0] = 32'hFFFF_FF80;
        addr[1] = 32'h1001; size[1] = LOAD_BYTE; uns[1] = 1'b1; exp[1] = 32'h0000_007F;
        addr[2] = 32'h1002; size[2] = LOAD_BYTE; uns[2] = 1'b1; exp[2] = 32'h0000_00FF;
        addr[3] = 32'h1002; size[3] = LOAD_HALF; uns[3] = 1'b0; exp[3] = 32'hFFFF_80FF;
        addr[4] = 32'h1003; size[4] = LOAD_HALF; uns[4] = 1'b1; exp[4] = 32'h0000_80FF;
        addr[5] = 32'h1001; size[5] = LOAD_HALF; uns[5] = 1'b0; exp[5] = 32'h0000_7F01;
        addr[6] = 32'h1000; size[6] = LOAD_WORD; uns[6] = 1'b0; exp[6] = 32'h80FF_7F01;
        addr[7] = 32'h1000; size[7] = LOAD_BYTE; uns[7] = 1'b0; exp[7] = 32'h0000_0001;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, WB_SEL_LOAD, addr[i], rd_word, 32'h0, 32'h0, size[i], uns[i], 5'd9, 1'b1);
            sample();
            checks++;
            if (bus.wb_data !== exp[i]) begin
                errors++;
                $display("FAIL load_%0d got=%h exp=%h", i, bus.wb_data, exp[i]);
            end
        end
    endtask

    task automatic test_link_imm();
        drive(1'b1, WB_SEL_LINK, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h3, LOAD_WORD, 1'b0, 5'd1, 1'b1);
        sample();
        checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL link_wrap got=%h exp=00000000", bus.wb_data); end
        drive(1'b1, WB_SEL_LINK, 32'h1, 32'h2, 32'h0000_0100, 32'h3, LOAD_WORD, 1'b0, 5'd1, 1'b1);
        sample();
        checks++; if (bus.wb_data !== 32'h0000_0104) begin errors++; $display("FAIL link got=%h exp=00000104", bus.wb_data); end
        drive(1'b1, WB_SEL_IMM, 32'h1, 32'h2, 32'h0000_0100, 32'hABCD_E000, LOAD_WORD, 1'b0, 5'd2, 1'b1);
        sample();
        checks++; if (bus.wb_data !== 32'hABCD_E000) begin errors++; $display("FAIL imm got=%h exp=abcde000", bus.wb_data); end
    endtask

    task automatic test_x0_invalid();
        drive(1'b1, WB_SEL_ALU, 32'h77, '0, '0, '0, LOAD_WORD, 1'b0, 5'd0, 1'b1);
        sample();
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL x0_valid got=%b exp=1", bus.wb_valid); end
        checks++; if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL x0_we got=%b exp=0", bus.wb_reg_write); end
        // Invalid bundle is still captured but never writes
        drive(1'b0, WB_SEL_ALU, 32'h88, '0, '0, '0, LOAD_WORD, 1'b0, 5'd3, 1'b1);
        sample();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL inv_valid got=%b exp=0", bus.wb_valid); end
        checks++; if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL inv_we got=%b exp=0", bus.wb_reg_write); end
        checks++; if (bus.wb_data !== 32'h88) begin errors++; $display("FAIL inv_data got=%h exp=00000088", bus.wb_data); end
        checks++; if (bus.wb_rd !== 5'd3) begin errors++; $display("FAIL inv_rd got=%0d exp=3", bus.wb_rd); end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, WB_SEL_ALU, 32'hA5A5_0001, '0, '0, '0, LOAD_WORD, 1'b0, 5'd10, 1'b1);
        sample();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, WB_SEL_IMM, 32'h0, '0, '0, 32'h1111_0000 + i, LOAD_WORD, 1'b0, 5'(20 + i), 1'b0);
            bus.stall = 1'b1;
            sample();
            checks++;
            if (bus.wb_data !== 32'hA5A5_0001 || bus.wb_rd !== 5'd10 ||
                bus.wb_valid !== 1'b1 || bus.wb_reg_write !== 1'b1) begin
                errors++;
                $display("FAIL stall_%0d got=%h/%0d/%b/%b exp=a5a50001/10/1/1",
                         i, bus.wb_data, bus.wb_rd, bus.wb_valid, bus.wb_reg_write);
            end
        end
        @(negedge clk);
        bus.flush = 1'b1;
        sample();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.wb_valid); end
        checks++; if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL flush_we got=%b exp=0", bus.wb_reg_write); end
        @(negedge clk);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, WB_SEL_ALU, 32'h0BAD_F00D, '0, '0, '0, LOAD_WORD, 1'b0, 5'd12, 1'b1);
        sample();
        checks++; if (bus.wb_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL pre_rst got=%h exp=0badf00d", bus.wb_data); end
        @(negedge clk);
        bus.stall = 1'b1;
        sample();
        @(negedge clk);
        rst = 1'b1;
        sample();
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.wb_reg_write !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_stall got=%b/%b/%0d/%h exp=0/0/0/00000000",
                     bus.wb_valid, bus.wb_reg_write, bus.wb_rd, bus.wb_data);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 1'b0;
        drive(1'b1, WB_SEL_IMM, '0, '0, '0, 32'h1357_9BDF, LOAD_WORD, 1'b0, 5'd31, 1'b1);
        sample();
        checks++;
        if (bus.wb_data !== 32'h1357_9BDF || bus.wb_rd !== 5'd31 || bus.wb_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL post_rst got=%h/%0d/%b exp=13579bdf/31/1", bus.wb_data, bus.wb_rd, bus.wb_reg_write);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h0000_0010; vals[1] = 32'hFFFF_0000; vals[2] = 32'h1234_5678; vals[3] = 32'h8000_0001;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, WB_SEL_ALU, vals[i], '0, '0, '0, LOAD_WORD, 1'b0, 5'(i + 1), 1'b1);
            sample();
            checks++;
            if (bus.wb_data !== vals[i] || bus.wb_rd !== 5'(i + 1)) begin
                errors++;
                $display("FAIL b2b_%0d got=%h/%0d exp=%h/%0d", i, bus.wb_data, bus.wb_rd, vals[i], i + 1);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_alu();
        test_load();
        test_link_imm();
        test_x0_invalid();
        test_stall_flush();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_select_stage
`default_nettype wire
